// File: rtl/logic_op_pipe.sv
// logic_op_pipe: bitwise-op stage feeding a DEPTH-deep valid/ready pipeline.
//
// Each accepted beat has AND/OR/XOR/NAND applied to in_a/in_b, selected by in_op
// for that beat. The result moves through DEPTH register stages. Backpressure is
// full: ready is computed combinationally from the output back to the input, so
// bubbles collapse and a full pipe can accept and drain in the same cycle.
// A saturating counter tracks delivered results.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears stages, data and counter)
//   in_valid   input beat valid
//   in_ready   input beat accepted this cycle (held 0 while rst is high)
//   in_a/in_b  operands, LANES*WIDTH bits
//   in_op      00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid  result valid (last stage occupied)
//   out_ready  consumer accepts result
//   out_data   result, LANES*WIDTH bits
//   count_clr  synchronous clear of out_count; wins over a same-cycle transfer
//   out_count  delivered results, saturating at 2^CNT_W-1
module logic_op_pipe #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned LANES = 4,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   input  logic [1:0]             in_op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   input  logic                   count_clr,
   output logic [CNT_W-1:0]       out_count
);

   localparam int unsigned DW = LANES * WIDTH;

   logic [DW-1:0]    op_result;
   logic [DEPTH-1:0] stage_valid_q;
   logic [DW-1:0]    stage_data_q [DEPTH];
   logic [DEPTH-1:0] stage_adv;
   logic             accept;
   logic [CNT_W-1:0] count_q;
   logic             count_sat;

   // The op is purely bitwise across the whole bus, so lanes need no separate handling.
   always_comb begin
      op_result = '0;
      unique case (in_op)
         2'b00:   op_result = in_a & in_b;
         2'b01:   op_result = in_a | in_b;
         2'b10:   op_result = in_a ^ in_b;
         2'b11:   op_result = ~(in_a & in_b);
         default: op_result = '0;
      endcase
   end

   // A stage advances when it holds a beat and something downstream frees a slot:
   // either the consumer takes the last beat or there is a bubble further along.
   // Unrolled as an accumulated "room" flag instead of a self-referencing chain.
   always_comb begin
      logic room;
      stage_adv = '0;
      room      = out_ready;
      for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
         stage_adv[s] = stage_valid_q[s] & room;
         room         = room | ~stage_valid_q[s];
      end
   end

   assign in_ready = ~rst & (~stage_valid_q[0] | stage_adv[0]);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid_q <= '0;
         for (int s = 0; s < int'(DEPTH); s++) begin
            stage_data_q[s] <= '0;
         end
      end else begin
         if (accept) begin
            stage_valid_q[0] <= 1'b1;
            stage_data_q[0]  <= op_result;
         end else if (stage_adv[0]) begin
            stage_valid_q[0] <= 1'b0;
         end
         for (int s = 1; s < int'(DEPTH); s++) begin
            if (stage_adv[s-1]) begin
               stage_valid_q[s] <= 1'b1;
               stage_data_q[s]  <= stage_data_q[s-1];
            end else if (stage_adv[s]) begin
               stage_valid_q[s] <= 1'b0;
            end
         end
      end
   end

   assign count_sat = (count_q == '1);

   always_ff @(posedge clk) begin
      if (rst || count_clr) begin
         count_q <= '0;
      end else if (stage_adv[DEPTH-1] && !count_sat) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign out_valid = stage_valid_q[DEPTH-1];
   assign out_data  = stage_data_q[DEPTH-1];
   assign out_count = count_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: directed self-checking bench for logic_op_pipe
// (LANES=4, WIDTH=1, DEPTH=2, CNT_W=4). Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_logic_op_pipe;

   localparam int unsigned W  = 1;
   localparam int unsigned L  = 4;
   localparam int unsigned D  = 2;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_a;
   logic [3:0]    in_b;
   logic [1:0]    in_op;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_data;
   logic          count_clr;
   logic [CW-1:0] out_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   logic_op_pipe #(
      .WIDTH(W),
      .LANES(L),
      .DEPTH(D),
      .CNT_W(CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_op    (in_op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .count_clr(count_clr),
      .out_count(out_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_op    = op;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Watchdog: the sequence below is fixed-length, this only guards against a stuck sim.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   logic [3:0] op_exp [4];
   logic [3:0] sa [8];
   logic [3:0] sb [8];
   logic [1:0] so [8];
   logic [3:0] se [8];
   logic [3:0] pa [3];
   logic [3:0] pb [3];
   logic [1:0] po [3];
   logic [3:0] pe [3];
   logic       er [5];

   initial begin
      int ptr;
      op_exp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
      sa = '{4'b0001, 4'b0101, 4'b1111, 4'b1100, 4'b1010, 4'b0000, 4'b1001, 4'b0110};
      sb = '{4'b0011, 4'b0011, 4'b0101, 4'b0110, 4'b1010, 4'b0000, 4'b0110, 4'b0111};
      so = '{2'b00,   2'b01,   2'b10,   2'b11,   2'b10,   2'b11,   2'b01,   2'b00};
      se = '{4'b0001, 4'b0111, 4'b1010, 4'b1011, 4'b0000, 4'b1111, 4'b1111, 4'b0110};
      pa = '{4'b1100, 4'b0011, 4'b1111};
      pb = '{4'b1010, 4'b0101, 4'b1111};
      po = '{2'b01,   2'b10,   2'b11};
      pe = '{4'b1110, 4'b0110, 4'b0000};
      er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset held with in_valid high.
      rst       = 1'b1;
      count_clr = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 4'b1111, 4'b1111, 2'b00);
      next_cycle();
      settle();
      check_val("rst_in_ready_0", 32'(in_ready), 0);
      next_cycle();
      settle();
      check_val("rst_in_ready_1", 32'(in_ready), 0);
      check_val("rst_out_valid", 32'(out_valid), 0);
      check_val("rst_out_data", 32'(out_data), 0);
      check_val("rst_out_count", 32'(out_count), 0);
      rst = 1'b0;
      drive(1'b0, 4'b0000, 4'b0000, 2'b00);

      // Each op with a=1100 b=1010, two-cycle latency.
      for (int op = 0; op < 4; op++) begin
         next_cycle();
         drive(1'b1, 4'b1100, 4'b1010, 2'(op));
         settle();
         check_val("op_in_ready", 32'(in_ready), 1);
         next_cycle();
         drive(1'b0, 4'b0000, 4'b0000, 2'b00);
         settle();
         check_val("op_lat1_valid", 32'(out_valid), 0);
         next_cycle();
         settle();
         check_val("op_lat2_valid", 32'(out_valid), 1);
         check_val("op_data", 32'(out_data), 32'(op_exp[op]));
         next_cycle();
         settle();
         check_val("op_drained", 32'(out_valid), 0);
      end
      check_val("op_count", 32'(out_count), 4);

      next_cycle();
      count_clr = 1'b1;
      next_cycle();
      count_clr = 1'b0;
      settle();
      check_val("clr_idle", 32'(out_count), 0);

      // Eight back-to-back beats with mixed ops.
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         if (c < 8) drive(1'b1, sa[c], sb[c], so[c]);
         else drive(1'b0, 4'b0000, 4'b0000, 2'b00);
         settle();
         if (c < 8) check_val("stream_in_ready", 32'(in_ready), 1);
         if (c >= 2) begin
            check_val("stream_valid", 32'(out_valid), 1);
            check_val("stream_data", 32'(out_data), 32'(se[c-2]));
         end
      end
      next_cycle();
      settle();
      check_val("stream_empty", 32'(out_valid), 0);
      check_val("stream_count", 32'(out_count), 8);

      // Backpressure: out_ready low while input is offered continuously.
      ptr = 0;
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         out_ready = 1'b0;
         drive(1'b1, pa[ptr], pb[ptr], po[ptr]);
         settle();
         check_val("bp_in_ready", 32'(in_ready), 32'(er[c]));
         if (er[c]) ptr++;
         if (c >= 2) begin
            check_val("bp_hold_valid", 32'(out_valid), 1);
            check_val("bp_hold_data", 32'(out_data), 32'(pe[0]));
         end
      end
      next_cycle();
      out_ready = 1'b1;
      drive(1'b1, pa[ptr], pb[ptr], po[ptr]);
      settle();
      check_val("bp_release_ready", 32'(in_ready), 1);
      check_val("bp_drain0", 32'(out_data), 32'(pe[0]));
      next_cycle();
      drive(1'b0, 4'b0000, 4'b0000, 2'b00);
      settle();
      check_val("bp_drain1_valid", 32'(out_valid), 1);
      check_val("bp_drain1", 32'(out_data), 32'(pe[1]));
      next_cycle();
      settle();
      check_val("bp_drain2_valid", 32'(out_valid), 1);
      check_val("bp_drain2", 32'(out_data), 32'(pe[2]));
      next_cycle();
      settle();
      check_val("bp_empty", 32'(out_valid), 0);
      check_val("bp_count", 32'(out_count), 11);

      // Counter saturation with 20 transfers.
      next_cycle();
      count_clr = 1'b1;
      next_cycle();
      count_clr = 1'b0;
      settle();
      check_val("sat_clr", 32'(out_count), 0);
      for (int c = 0; c < 22; c++) begin
         next_cycle();
         if (c < 20) drive(1'b1, 4'(c), 4'hf, 2'b00);
         else drive(1'b0, 4'b0000, 4'b0000, 2'b00);
         settle();
         if (c == 16) check_val("sat_mid", 32'(out_count), 14);
      end
      next_cycle();
      settle();
      check_val("sat_count", 32'(out_count), 15);
      check_val("sat_empty", 32'(out_valid), 0);

      // count_clr coincident with a transfer.
      next_cycle();
      drive(1'b1, 4'b0011, 4'b0001, 2'b00);
      next_cycle();
      drive(1'b1, 4'b0110, 4'b0011, 2'b10);
      next_cycle();
      drive(1'b0, 4'b0000, 4'b0000, 2'b00);
      count_clr = 1'b1;
      settle();
      check_val("clrx_valid", 32'(out_valid), 1);
      check_val("clrx_data", 32'(out_data), 32'(4'b0001));
      next_cycle();
      count_clr = 1'b0;
      settle();
      check_val("clrx_count0", 32'(out_count), 0);
      check_val("clrx_data2", 32'(out_data), 32'(4'b0101));
      next_cycle();
      settle();
      check_val("clrx_count1", 32'(out_count), 1);
      check_val("clrx_empty", 32'(out_valid), 0);

      // Reset with two beats in flight.
      next_cycle();
      out_ready = 1'b0;
      drive(1'b1, 4'b1111, 4'b0000, 2'b01);
      next_cycle();
      drive(1'b1, 4'b1010, 4'b0101, 2'b00);
      next_cycle();
      drive(1'b0, 4'b0000, 4'b0000, 2'b00);
      rst = 1'b1;
      settle();
      check_val("mid_full_valid", 32'(out_valid), 1);
      check_val("mid_rst_ready", 32'(in_ready), 0);
      next_cycle();
      rst       = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 4'b1100, 4'b1010, 2'b10);
      settle();
      check_val("mid_valid", 32'(out_valid), 0);
      check_val("mid_data", 32'(out_data), 0);
      check_val("mid_count", 32'(out_count), 0);
      check_val("mid_in_ready", 32'(in_ready), 1);
      next_cycle();
      drive(1'b0, 4'b0000, 4'b0000, 2'b00);
      settle();
      check_val("mid_lat1", 32'(out_valid), 0);
      next_cycle();
      settle();
      check_val("mid_lat2", 32'(out_valid), 1);
      check_val("mid_lat2_data", 32'(out_data), 32'(4'b0110));
      next_cycle();
      settle();
      check_val("mid_end_valid", 32'(out_valid), 0);
      check_val("mid_end_count", 32'(out_count), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
